// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC bits. Lookups return a registered direction one cycle later.
// Lookups and updates to the same index in one cycle return the updated count.
// Ports: clk, rst_n (async, active-low)
//   lookup:  lkp_req, lkp_pc, lkp_flush -> pred_vld, pred_taken
//   update:  upd_vld, upd_pc, upd_taken, upd_pred -> mispredict
// Optional: define BRANCH_PREDICTOR_PERF_EN to add the outputs
//   br_cnt and mispred_cnt (saturating counters of updates and mispredicts).
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lkp_req,
  input  logic [31:0] lkp_pc,
  input  logic        lkp_flush,
  output logic        pred_vld,
  output logic        pred_taken,
  input  logic        upd_vld,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
`ifdef BRANCH_PREDICTOR_PERF_EN
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt,
`endif
  output logic        mispredict
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic [1:0]    bht [BHT_ENTRIES];
  logic [IW-1:0] lkp_idx;
  logic [IW-1:0] upd_idx;
  logic [1:0]    upd_old;
  logic [1:0]    upd_new;
  logic [1:0]    lkp_cnt;
  logic          lkp_go;
  logic          mis_now;
  logic          unused;

  // Only the index field of each PC matters; the rest aliases.
  assign unused  = ^{lkp_pc, upd_pc};
  assign lkp_idx = lkp_pc[IDX_LSB +: IW];
  assign upd_idx = upd_pc[IDX_LSB +: IW];
  assign lkp_go  = lkp_req && !lkp_flush;
  assign mis_now = upd_vld && (upd_taken != upd_pred);

  always_comb begin
    upd_old = bht[upd_idx];
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
    end
  end

  // Same-index update forwards the post-update count to the lookup.
  always_comb begin
    lkp_cnt = bht[lkp_idx];
    if (upd_vld && (upd_idx == lkp_idx)) lkp_cnt = upd_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_vld) begin
      bht[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      pred_vld   <= lkp_go;
      pred_taken <= lkp_go && lkp_cnt[1];
      mispredict <= mis_now;
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_vld && (br_cnt != 32'hFFFF_FFFF))
        br_cnt <= br_cnt + 32'd1;
      if (mis_now && (mispred_cnt != 32'hFFFF_FFFF))
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic checked against a table model.
module tb_branch_predictor;

  localparam int N   = 64;
  localparam int LSB = 2;

  logic        clk;
  logic        rst_n;
  logic        lkp_req;
  logic [31:0] lkp_pc;
  logic        lkp_flush;
  logic        pred_vld;
  logic        pred_taken;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
`endif

  branch_predictor #(.BHT_ENTRIES(N), .IDX_LSB(LSB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lkp_req(lkp_req),
    .lkp_pc(lkp_pc),
    .lkp_flush(lkp_flush),
    .pred_vld(pred_vld),
    .pred_taken(pred_taken),
    .upd_vld(upd_vld),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_pred(upd_pred),
`ifdef BRANCH_PREDICTOR_PERF_EN
    .br_cnt(br_cnt),
    .mispred_cnt(mispred_cnt),
`endif
    .mispredict(mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: counters as plain integers 0..3.
  int  m_cnt [N];
  bit  e_vld, e_tkn, e_mis;
  longint e_br, e_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> LSB) % N);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 1;
      e_vld = 0; e_tkn = 0; e_mis = 0;
      e_br = 0; e_mp = 0;
    end else begin
      e_mis = upd_vld && (upd_taken != upd_pred);
      if (upd_vld) begin
        int k;
        k = idx_of(upd_pc);
        if (upd_taken) m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
        else           m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
        e_br++;
        if (e_mis) e_mp++;
      end
      e_vld = lkp_req && !lkp_flush;
      e_tkn = e_vld && (m_cnt[idx_of(lkp_pc)] >= 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_pred_vld", {31'd0, pred_vld}, {31'd0, e_vld});
      if (e_vld) chk("m_pred_taken", {31'd0, pred_taken}, {31'd0, e_tkn});
      chk("m_mispredict", {31'd0, mispredict}, {31'd0, e_mis});
`ifdef BRANCH_PREDICTOR_PERF_EN
      chk("m_br_cnt", br_cnt, e_br[31:0]);
      chk("m_mispred_cnt", mispred_cnt, e_mp[31:0]);
`endif
    end
  end

  task automatic idle();
    lkp_req = 0; lkp_pc = $urandom; lkp_flush = 0;
    upd_vld = 0; upd_pc = $urandom;
    upd_taken = 1'($urandom); upd_pred = 1'($urandom);
  endtask

  // Called at a negedge; returns at the next negedge with inputs idle.
  task automatic drive(input logic lr, input logic [31:0] lpc,
                       input logic lf, input logic uv,
                       input logic [31:0] upc, input logic ut,
                       input logic up);
    lkp_req = lr; lkp_pc = lpc; lkp_flush = lf;
    upd_vld = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    @(negedge clk);
    idle();
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive(1, pc, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic p);
    drive(0, 32'h0, 0, 1, pc, t, p);
  endtask

  // Reset asserted with a prediction pending on the outputs.
  task automatic do_reset();
    lookup(32'h0000_0010);
    chk("pre_rst_vld", {31'd0, pred_vld}, 32'd1);
    drive(1, 32'h0000_0010, 0, 1, 32'h0000_0010, 0, 1);
    rst_n = 0;
    #1;
    chk("rst_vld", {31'd0, pred_vld}, 32'd0);
    chk("rst_tkn", {31'd0, pred_taken}, 32'd0);
    chk("rst_mis", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    idle();
    #2 rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    lookup(32'h100);
    chk("reset_lookup_vld", {31'd0, pred_vld}, 32'd1);
    chk("reset_lookup_tkn", {31'd0, pred_taken}, 32'd0);

    update(32'h100, 1, 0);
    update(32'h100, 1, 0);
    lookup(32'h100);
    chk("train2_tkn", {31'd0, pred_taken}, 32'd1);
    repeat (3) update(32'h100, 1, 1);
    update(32'h100, 0, 1);
    lookup(32'h100);
    chk("train_hyst_tkn", {31'd0, pred_taken}, 32'd1);

    repeat (5) update(32'h40, 0, 0);
    update(32'h40, 1, 0);
    lookup(32'h40);
    chk("sat_low_tkn", {31'd0, pred_taken}, 32'd0);

    do_reset();
    lookup(32'h100);
    chk("post_rst_tkn", {31'd0, pred_taken}, 32'd0);
    drive(1, 32'h200, 0, 1, 32'h200, 1, 0);
    chk("bypass_vld", {31'd0, pred_vld}, 32'd1);
    chk("bypass_tkn", {31'd0, pred_taken}, 32'd1);

    update(32'h300, 1, 0);
    chk("mis_pulse", {31'd0, mispredict}, 32'd1);
    @(negedge clk);
    chk("mis_clear", {31'd0, mispredict}, 32'd0);
    drive(1, 32'h300, 1, 0, 32'h0, 0, 0);
    chk("flush_vld", {31'd0, pred_vld}, 32'd0);

    update(32'h004, 1, 0);
    update(32'h004, 1, 1);
    lookup(32'h104);
    chk("alias_tkn", {31'd0, pred_taken}, 32'd1);

    do_reset();
    for (int i = 0; i < 10; i++) update(32'h80 + 32'(i * 4), 1, i >= 3);
`ifdef BRANCH_PREDICTOR_PERF_EN
    chk("perf_br", br_cnt, 32'd10);
    chk("perf_mis", mispred_cnt, 32'd3);
`endif

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] hi1, hi2;
      hi1 = $urandom & 32'hFFFF_FF00;
      hi2 = $urandom & 32'hFFFF_FF00;
      lkp_req   = ($urandom_range(0, 3) != 0);
      lkp_pc    = hi1 | (32'($urandom_range(0, 7)) << LSB);
      lkp_flush = ($urandom_range(0, 9) == 0);
      upd_vld   = ($urandom_range(0, 2) != 0);
      upd_pc    = hi2 | (32'($urandom_range(0, 7)) << LSB);
      upd_taken = 1'($urandom);
      upd_pred  = 1'($urandom);
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
